// File: rtl/seg_display_scheduler.sv
// Eight-digit seven-segment scan scheduler with two
// round-robin arbitrated writers, per-digit blink and clear.
module seg_display_scheduler #(
  parameter int DIV       = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic [2:0] wr_pos1,
  input  logic [6:0] wr_seg1,
  input  logic       wr_blink1,
  output logic       gnt1,
  input  logic       req2,
  input  logic [2:0] wr_pos2,
  input  logic [6:0] wr_seg2,
  input  logic       wr_blink2,
  output logic       gnt2,
  input  logic       clear,
  output logic [6:0] data_out,
  output logic [7:0] data_pos,
  output logic       scan_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [6:0]    pattern [8];
  logic [7:0]    blink;
  logic [2:0]    idx;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic          phase;
  // 0 = player1 wins a tie, 1 = player2 wins a tie
  logic          ptr;

  logic          wr_en;
  logic [2:0]    wr_pos;
  logic [6:0]    wr_seg;
  logic          wr_blk;

  // Grant: sole requester wins, ties go to the pointer side
  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (!rst && !clear) begin
      if (req1 && (!req2 || !ptr)) begin
        gnt1 = 1'b1;
      end else if (req2) begin
        gnt2 = 1'b1;
      end
    end
  end

  // Mux the granted player's write onto the buffer port
  always_comb begin
    wr_en  = gnt1 | gnt2;
    wr_pos = gnt2 ? wr_pos2 : wr_pos1;
    wr_seg = gnt2 ? wr_seg2 : wr_seg1;
    wr_blk = gnt2 ? wr_blink2 : wr_blink1;
  end

  // Pointer flips only after a contested grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (req1 && req2 && wr_en) begin
      ptr <= ~ptr;
    end
  end

  // Pattern and blink buffer: reset/clear wipe, else one write
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 8; i++) begin
        pattern[i] <= 7'h00;
      end
      blink <= 8'h00;
    end else if (wr_en) begin
      pattern[wr_pos] <= wr_seg;
      blink[wr_pos]   <= wr_blk;
    end
  end

  // Prescaler, digit index and blink phase counters
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 3'd0;
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (presc == PMAX) begin
      presc <= '0;
      idx   <= idx + 3'd1;
      if (idx == 3'd7) begin
        if (bcnt == BMAX) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered scan outputs, one cycle behind the index
  always_ff @(posedge clk) begin
    if (rst) begin
      data_pos  <= 8'h00;
      data_out  <= 7'h00;
      scan_done <= 1'b0;
    end else begin
      data_pos  <= 8'h01 << idx;
      data_out  <= (blink[idx] && phase) ? 7'h00
                                         : pattern[idx];
      scan_done <= data_pos[7] && (idx == 3'd0);
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler, DIV=4,
// BLINK_DIV=2; a cycle model pushes expected scan outputs.
module tb_seg_display_scheduler;

  localparam int DIV = 4;
  localparam int BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req1 = 1'b0, req2 = 1'b0;
  logic [2:0] wr_pos1 = '0, wr_pos2 = '0;
  logic [6:0] wr_seg1 = '0, wr_seg2 = '0;
  logic       wr_blink1 = 1'b0, wr_blink2 = 1'b0;
  logic       gnt1, gnt2;
  logic       clear = 1'b0;
  logic [6:0] data_out;
  logic [7:0] data_pos;
  logic       scan_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] pos;
    logic [6:0] out;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t e;

  seg_display_scheduler #(
    .DIV(DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .wr_pos1(wr_pos1),
    .wr_seg1(wr_seg1), .wr_blink1(wr_blink1),
    .gnt1(gnt1),
    .req2(req2), .wr_pos2(wr_pos2),
    .wr_seg2(wr_seg2), .wr_blink2(wr_blink2),
    .gnt2(gnt2),
    .clear(clear),
    .data_out(data_out), .data_pos(data_pos),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Reference model, derived from cycle count since reset
  logic [6:0] m_pat [8];
  logic [7:0] m_blk;
  logic       m_ptr;
  int         k;
  int         mi, mph;
  logic       g1, g2;
  exp_t       me;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      for (int i = 0; i < 8; i++) m_pat[i] = 7'h00;
      m_blk = 8'h00;
      m_ptr = 1'b0;
      me.pos = 8'h00;
      me.out = 7'h00;
      me.done = 1'b0;
      q.push_back(me);
    end else begin
      k++;
      mi = ((k - 1) / DIV) % 8;
      mph = ((k - 1) / (8 * DIV * BLINK_DIV)) % 2;
      me.pos = 8'h01 << mi;
      me.out = (m_blk[mi] && mph == 1) ? 7'h00 : m_pat[mi];
      me.done = (k > 1) && ((k - 1) % (8 * DIV) == 0);
      q.push_back(me);
      g1 = !clear && req1 && (!req2 || !m_ptr);
      g2 = !clear && req2 && !g1;
      if (clear) begin
        for (int i = 0; i < 8; i++) m_pat[i] = 7'h00;
        m_blk = 8'h00;
      end else if (g1) begin
        m_pat[wr_pos1] = wr_seg1;
        m_blk[wr_pos1] = wr_blink1;
      end else if (g2) begin
        m_pat[wr_pos2] = wr_seg2;
        m_blk[wr_pos2] = wr_blink2;
      end
      if (req1 && req2 && (g1 || g2)) m_ptr = !m_ptr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (q.size() > 0) e = q.pop_front();
  endtask

  task automatic test_reset();
    req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_pos !== 8'h00 || data_out !== 7'h00
          || scan_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_out pos=%h out=%h done=%b need 0",
                 data_pos, data_out, scan_done);
      end
      checks++;
      if (gnt1 !== 1'b0 || gnt2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_gnt g1=%b g2=%b need 0",
                 gnt1, gnt2);
      end
    end
    req1 = 1'b0;
  endtask

  task automatic test_scan();
    int dones = 0;
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (data_pos !== 8'h01) begin
          failures++;
          $display("FAIL first_pos got=%h need 01", data_pos);
        end
      end
      if (i <= 33 && scan_done === 1'b1) dones++;
      checks++;
      if (data_pos !== e.pos || data_out !== e.out
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL scan c%0d got %h/%h/%b need %h/%h/%b",
                 i, data_pos, data_out, scan_done,
                 e.pos, e.out, e.done);
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL scan_done_count got=%0d need 1", dones);
    end
  endtask

  task automatic test_single_write();
    req1 = 1'b1;
    wr_pos1 = 3'd3;
    wr_seg1 = 7'h06;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt g1=%b g2=%b need 1/0",
               gnt1, gnt2);
    end
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (data_pos !== e.pos || data_out !== e.out
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL single c%0d got %h/%h need %h/%h",
                 i, data_pos, data_out, e.pos, e.out);
      end
      if (data_pos === 8'h08) begin
        checks++;
        if (data_out !== 7'h06) begin
          failures++;
          $display("FAIL single_d3 got=%h need 06", data_out);
        end
      end
    end
  endtask

  task automatic test_contention();
    for (int r = 0; r < 2; r++) begin
      req1 = 1'b1; wr_pos1 = 3'd0; wr_seg1 = 7'h30;
      req2 = 1'b1; wr_pos2 = 3'd1; wr_seg2 = 7'h6D;
      #1;
      checks++;
      if (gnt1 !== (r == 0) || gnt2 !== (r == 1)) begin
        failures++;
        $display("FAIL tie_first r%0d g1=%b g2=%b", r,
                 gnt1, gnt2);
      end
      tick();
      if (r == 0) req1 = 1'b0;
      else req2 = 1'b0;
      #1;
      checks++;
      if (gnt1 !== (r == 1) || gnt2 !== (r == 0)) begin
        failures++;
        $display("FAIL tie_second r%0d g1=%b g2=%b", r,
                 gnt1, gnt2);
      end
      tick();
      req1 = 1'b0;
      req2 = 1'b0;
    end
    for (int i = 0; i < 34; i++) begin
      tick();
      checks++;
      if (data_pos !== e.pos || data_out !== e.out
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL tie_scan c%0d got %h/%h need %h/%h",
                 i, data_pos, data_out, e.pos, e.out);
      end
    end
  endtask

  task automatic test_blink();
    int on = 0;
    int off = 0;
    req2 = 1'b1; wr_pos2 = 3'd5;
    wr_seg2 = 7'h7F; wr_blink2 = 1'b1;
    #1;
    checks++;
    if (gnt2 !== 1'b1) begin
      failures++;
      $display("FAIL blink_gnt got=%b need 1", gnt2);
    end
    tick();
    req2 = 1'b0;
    wr_blink2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (data_pos !== e.pos || data_out !== e.out
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL blink c%0d got %h/%h need %h/%h",
                 i, data_pos, data_out, e.pos, e.out);
      end
      if (data_pos === 8'h20 && data_out === 7'h7F) on++;
      if (data_pos === 8'h20 && data_out === 7'h00) off++;
    end
    checks++;
    if (on == 0 || off == 0) begin
      failures++;
      $display("FAIL blink_alt on=%0d off=%0d need both >0",
               on, off);
    end
  endtask

  task automatic test_clear();
    req1 = 1'b1; wr_pos1 = 3'd2; wr_seg1 = 7'h11;
    clear = 1'b1;
    #1;
    checks++;
    if (gnt1 !== 1'b0 || gnt2 !== 1'b0) begin
      failures++;
      $display("FAIL clear_gnt g1=%b g2=%b need 0",
               gnt1, gnt2);
    end
    tick();
    clear = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (data_pos !== e.pos || data_out !== 7'h00
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL clear c%0d got %h/%h need %h/00",
                 i, data_pos, data_out, e.pos);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    req1 = 1'b1; wr_pos1 = 3'd6; wr_seg1 = 7'h22;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (e.pos == 8'h10) found = 1;
    end
    checks++;
    if (!found || data_pos !== 8'h10) begin
      failures++;
      $display("FAIL mid_wait got=%h need 10", data_pos);
    end
    rst = 1'b1;
    req2 = 1'b1; wr_pos2 = 3'd4; wr_seg2 = 7'h55;
    #1;
    checks++;
    if (gnt2 !== 1'b0 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL mid_gnt g2=%b need 0", gnt2);
    end
    tick();
    checks++;
    if (data_pos !== 8'h00 || data_out !== 7'h00
        || scan_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got %h/%h need 00/00",
               data_pos, data_out);
    end
    rst = 1'b0;
    req2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (data_pos !== e.pos || data_out !== e.out
          || scan_done !== e.done) begin
        failures++;
        $display("FAIL mid_scan c%0d got %h/%h need %h/%h",
                 i, data_pos, data_out, e.pos, e.out);
      end
      if (i == 0) begin
        checks++;
        if (data_pos !== 8'h01 || data_out !== 7'h00) begin
          failures++;
          $display("FAIL mid_restart got %h/%h need 01/00",
                   data_pos, data_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_write();
    test_contention();
    test_blink();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Owns an 8-digit pattern buffer that drives the seven-segment scan outputs.
- Two requesters (player1, player2, each fed by its own display encoder) write 7-bit digit patterns through a round-robin arbitrated req/gnt handshake.
- A prescaled scan counter time-multiplexes the buffer onto the shared segment/position pins.
- Per-digit blink and a global clear are supported.

Parameters:
- DIV, 1000: clk cycles per digit slot; legal range >= 1.
- BLINK_DIV, 64: full 8-digit scans per blink half-period; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req1  in  1  player1 write request; held with its data until gnt1
- wr_pos1  in  3  player1 target digit index, 0..7
- wr_seg1  in  7  player1 pattern; bit6..0 = segments a..g, 1 = lit
- wr_blink1  in  1  player1 blink enable for the target digit
- gnt1  out  1  player1 grant; write commits on this clock edge
- req2, wr_pos2, wr_seg2, wr_blink2, gnt2  same as player1, for player2
- clear  in  1  zero all patterns and blink bits
- data_out  out  7  segment pattern of the digit currently scanned
- data_pos  out  8  one-hot, active-high digit select
- scan_done  out  1  one-cycle pulse at each 7->0 index wrap

Behaviour:
- Reset (rst=1 at a clock edge), applied from any state including mid-scan or mid-request:
  - pattern[0..7]=0, blink[0..7]=0, scan index=0, prescale=0, blink scan count=0, blink_phase=0, rr pointer=player1.
  - data_out=7'h00, data_pos=8'h00, scan_done=0.
  - gnt1=gnt2=0 while rst=1.
- Arbitration (gnt is combinational from req, pointer, clear and rst):
  - Only one req high: that requester is granted.
  - Both req high: the pointer side is granted. After a grant, the pointer moves to the other player.
  - clear=1 or rst=1 forces gnt1=gnt2=0.
  - A write commits at the edge where req & gnt = 1: pattern[wr_pos] <= wr_seg, blink[wr_pos] <= wr_blink.
  - At most one write per cycle.
  - A losing requester keeps req high; it is granted on the next cycle.
  - Dropping req before gnt is legal; no write occurs.
- Clear: at the edge where clear=1 (and rst=0), all patterns and blink bits become 0. Scan counters, pointer and blink_phase are unaffected.
- Scan counters:
  - prescale counts 0..DIV-1 and wraps to 0.
  - When prescale=DIV-1, index increments modulo 8.
  - DIV=1: index advances every cycle.
- Scan wrap and blink:
  - On the 7->0 index wrap, the blink scan count increments.
  - When the blink scan count reaches BLINK_DIV-1 and wraps, blink_phase toggles.
- Outputs are registered, one-cycle latency from the internal index and buffer:
  - data_pos = one-hot(index).
  - data_out = 0 if blink[index] and blink_phase, otherwise pattern[index].
  - scan_done=1 for exactly the cycle in which data_pos first shows 8'h01 after 8'h80.
- The first cycle after reset release shows data_pos=8'h01.
- A write to the digit currently scanned is visible on data_out on the cycle after the commit edge.
- Simultaneous write and scan advance: the index advances normally; the write lands in the buffer regardless of index.

Test Plan (DIV=4, BLINK_DIV=2):
- Reset release -> data_pos sequence 01 (x4 cycles), 02 (x4), ..., 80 (x4), then 01 with scan_done=1 for one cycle; data_out=0 throughout.
- req1 only, wr_pos1=3, wr_seg1=7'h06, held -> gnt1=1 in the same cycle; when data_pos=8'h08, data_out=7'h06; other digits stay 0.
- req1 and req2 asserted together (pos 0 = 7'h30, pos 1 = 7'h6D), pointer at player1:
  - gnt1 on cycle 0, gnt2 on cycle 1.
  - Repeat both requests -> player2 is granted first.
- Set wr_blink2=1 at pos 5 with pattern 7'h7F -> data_out at data_pos=8'h20 alternates 7'h7F / 0, every 2 full scans (64 cycles per phase).
- clear asserted with req1 high -> gnt1=0 that cycle; all digits read 0 in the next scan; scan timing is undisturbed.
- rst asserted mid-scan (data_pos=8'h10) with req2 pending -> next cycle data_out=0, data_pos=0, gnt2=0; after release, the scan restarts at 8'h01 and all patterns are 0.
